stream_fifo: RTL and testbench

- Buffering FIFO that sits between fifo_writer (upstream) and fifo_reader (downstream) in the filter datapath.
- It is the passive responder to both active handshake initiators:
  - accepts words pushed by fifo_writer's req/ack output;
  - serves words pulled by fifo_reader's req/ack input;
  - drives the full/empty flags those blocks already consume.
- Decouples the producer and consumer ends of the sample-block stream.

---
 rtl/stream_fifo_pkg.sv | 19 +
 rtl/stream_fifo_mem.sv | 39 +++
 rtl/stream_fifo.sv | 124 ++++++++++++
 tb/tb_stream_fifo.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared handshake and sizing constants for the filter datapath blocks
// (fifo_writer, fifo_reader, stream_fifo).
package stream_fifo_pkg;

    // Acknowledge pulses last exactly one clock cycle.
    localparam int ACK_PULSE      = 1;

    // Default sample-block word width.
    localparam int C_SLV_DWIDTH   = 32;

    // Default FIFO depth expressed as log2(entries).
    localparam int FIFO_DEPTH_LOG = 4;

    // Number of storage entries for a given log2 depth.
    function automatic int fifo_depth(input int depth_log);
        return 1 << depth_log;
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Simple dual-port storage for stream_fifo: synchronous write, registered
// read, no reset so the array maps onto block or distributed RAM.
module stream_fifo_mem
    import stream_fifo_pkg::*;
#(
    parameter int DWIDTH    = C_SLV_DWIDTH,
    parameter int DEPTH_LOG = FIFO_DEPTH_LOG
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [DEPTH_LOG-1:0] waddr,
    input  logic [0:DWIDTH-1]    wdata,
    input  logic                 re,
    input  logic [DEPTH_LOG-1:0] raddr,
    output logic [0:DWIDTH-1]    rdata
);

    localparam int DEPTH = fifo_depth(DEPTH_LOG);

    logic [0:DWIDTH-1] mem [DEPTH];
    logic [0:DWIDTH-1] rdata_q;

    // Write port: store the incoming word when the controller accepts it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: capture the addressed word; the register holds between reads.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/stream_fifo.sv
// Buffering FIFO between fifo_writer and fifo_reader. Both sides initiate
// req/ack handshakes; this block only responds, and publishes registered
// full/empty flags plus the fill level.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int DWIDTH    = C_SLV_DWIDTH,
    parameter int DEPTH_LOG = FIFO_DEPTH_LOG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_req,
    output logic                 wr_ack,
    input  logic [0:DWIDTH-1]    wr_data,
    output logic                 full,
    input  logic                 rd_req,
    output logic                 rd_ack,
    output logic [0:DWIDTH-1]    rd_data,
    output logic                 empty,
    output logic [DEPTH_LOG:0]   level
);

    // Fill count that means "every entry occupied".
    localparam logic [DEPTH_LOG:0] LEVEL_FULL = {1'b1, {DEPTH_LOG{1'b0}}};

    logic [DEPTH_LOG-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG:0]   level_q, level_d;
    logic                 wr_ack_q, wr_ack_d;
    logic                 rd_ack_q, rd_ack_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    // Cleared by reset, set by the first clock edge afterwards; transfers
    // are held off until then so the first one lands on the second edge.
    logic                 run_q, run_d;
    // Set once any word has been read; until then rd_data reads as zero
    // because the RAM read register itself has no reset.
    logic                 rd_valid_q, rd_valid_d;

    logic                 wr_fire;
    logic                 rd_fire;
    logic [0:DWIDTH-1]    mem_rdata;

    // Accept/serve decisions use only registered state and the req levels;
    // the ack terms enforce the one-cycle pulse and 2-cycle minimum spacing.
    always_comb begin
        wr_fire = run_q && wr_req && !wr_ack_q && !full_q;
        rd_fire = run_q && rd_req && !rd_ack_q && !empty_q;
    end

    // Next-state for pointers, level, flags and acknowledges.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        run_d      = 1'b1;
        rd_valid_d = rd_valid_q || rd_fire;
        wr_ack_d   = wr_fire;
        rd_ack_d   = rd_fire;

        if (wr_fire) begin
            wptr_d = wptr_q + DEPTH_LOG'(1);
        end
        if (rd_fire) begin
            rptr_d = rptr_q + DEPTH_LOG'(1);
        end

        unique case ({wr_fire, rd_fire})
            2'b10:   level_d = level_q + (DEPTH_LOG+1)'(1);
            2'b01:   level_d = level_q - (DEPTH_LOG+1)'(1);
            default: level_d = level_q;
        endcase

        // Flags follow the new level so they are valid right after the edge.
        full_d  = (level_d == LEVEL_FULL);
        empty_d = (level_d == '0);
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            run_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            run_q      <= run_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    stream_fifo_mem #(
        .DWIDTH    (DWIDTH),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_mem (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wptr_q),
        .wdata (wr_data),
        .re    (rd_fire),
        .raddr (rptr_q),
        .rdata (mem_rdata)
    );

    assign wr_ack  = wr_ack_q;
    assign rd_ack  = rd_ack_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;
    assign rd_data = rd_valid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_stream_fifo.sv
// Directed plus randomized bench for stream_fifo, checked against a
// queue-based transaction model.
module tb_stream_fifo;

    localparam int DW    = 32;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic          rd_req = 1'b0;
    logic [0:DW-1] wr_data = '0;
    logic          wr_ack;
    logic          rd_ack;
    logic          full;
    logic          empty;
    logic [0:DW-1] rd_data;
    logic [DL:0]   level;

    int total = 0;
    int bad   = 0;

    stream_fifo #(.DWIDTH(DW), .DEPTH_LOG(DL)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_req  (wr_req),
        .wr_ack  (wr_ack),
        .wr_data (wr_data),
        .full    (full),
        .rd_req  (rd_req),
        .rd_ack  (rd_ack),
        .rd_data (rd_data),
        .empty   (empty),
        .level   (level)
    );

    initial forever #5 clk = ~clk;

    // Reference model: word queue plus the handshake rules, stepped per edge.
    logic [31:0] mq[$];
    logic        m_wr_ack  = 1'b0;
    logic        m_rd_ack  = 1'b0;
    logic [31:0] m_rd_data = '0;
    logic        m_run     = 1'b0;
    logic        m_wf, m_rf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_wr_ack  = 1'b0;
            m_rd_ack  = 1'b0;
            m_rd_data = '0;
            m_run     = 1'b0;
        end else begin
            m_wf = m_run && wr_req && !m_wr_ack && (mq.size() < DEPTH);
            m_rf = m_run && rd_req && !m_rd_ack && (mq.size() > 0);
            if (m_rf) m_rd_data = mq.pop_front();
            if (m_wf) mq.push_back(wr_data);
            m_wr_ack = m_wf;
            m_rd_ack = m_rf;
            m_run    = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        chk("wr_ack", 64'(wr_ack), 64'(m_wr_ack));
        chk("rd_ack", 64'(rd_ack), 64'(m_rd_ack));
        chk("rd_data", 64'(rd_data), 64'(m_rd_data));
        chk("level", 64'(level), 64'(mq.size()));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("full", 64'(full), 64'(mq.size() == DEPTH));
        chk("level_bound", 64'(level <= DEPTH), 64'd1);
    endtask

    // Advance one edge and compare all outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic write_word(input logic [31:0] d);
        bit got;
        got = 1'b0;
        wr_data = d;
        wr_req  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wr_ack) begin
                got = 1'b1;
                break;
            end
        end
        wr_req = 1'b0;
        chk("wr_timeout", 64'(got), 64'd1);
    endtask

    task automatic read_word(output logic [31:0] d);
        bit got;
        got = 1'b0;
        rd_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rd_ack) begin
                got = 1'b1;
                break;
            end
        end
        rd_req = 1'b0;
        d = rd_data;
        chk("rd_timeout", 64'(got), 64'd1);
    endtask

    task automatic mid_cycle_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_wr_ack", 64'(wr_ack), 64'd0);
        chk("rst_rd_ack", 64'(rd_ack), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        #1 rst = 1'b0;
    endtask

    logic [31:0] rv;
    int          nw, nr;

    initial begin
        // Power-on reset, then idle.
        repeat (2) @(posedge clk);
        #1;
        cmp_all();
        rst = 1'b0;
        tick();

        // Mid-cycle reset pulse with no clock edge in between.
        mid_cycle_reset();

        // Single transfer; the first edge after reset release moves nothing.
        wr_data = 32'h12345678;
        wr_req  = 1'b1;
        tick();
        chk("post_rst_no_ack", 64'(wr_ack), 64'd0);
        tick();
        chk("single_wr_ack", 64'(wr_ack), 64'd1);
        chk("single_level1", 64'(level), 64'd1);
        chk("single_empty0", 64'(empty), 64'd0);
        wr_req = 1'b0;
        rd_req = 1'b1;
        tick();
        chk("single_rd_ack", 64'(rd_ack), 64'd1);
        chk("single_rd_data", 64'(rd_data), 64'h12345678);
        chk("single_level0", 64'(level), 64'd0);
        rd_req = 1'b0;
        tick();
        chk("single_rd_hold", 64'(rd_data), 64'h12345678);

        // Fill to full, then a blocked 17th word.
        for (int i = 1; i <= 16; i++) write_word(32'(i));
        tick();
        chk("fill_level16", 64'(level), 64'd16);
        chk("fill_full", 64'(full), 64'd1);
        wr_data = 32'hDEADBEEF;
        wr_req  = 1'b1;
        repeat (3) begin
            tick();
            chk("full_stall", 64'(wr_ack), 64'd0);
        end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("full_rd_ack", 64'(rd_ack), 64'd1);
        chk("full_rd_data", 64'(rd_data), 64'd1);
        chk("full_no_wr_same_edge", 64'(wr_ack), 64'd0);
        chk("full_level15", 64'(level), 64'd15);
        tick();
        wr_req = 1'b0;
        chk("full_late_wr_ack", 64'(wr_ack), 64'd1);
        chk("full_level16_again", 64'(level), 64'd16);
        for (int i = 2; i <= 16; i++) begin
            read_word(rv);
            chk("drain_data", 64'(rv), 64'(i));
        end
        read_word(rv);
        chk("drain_deadbeef", 64'(rv), 64'hDEADBEEF);
        tick();
        chk("drain_empty", 64'(empty), 64'd1);

        // Order and wrap with continuous requests on both sides.
        nw = 0;
        nr = 0;
        wr_data = 32'd0;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        for (int c = 0; c < 600 && nr < 40; c++) begin
            tick();
            if (wr_ack) begin
                nw++;
                if (nw == 40) wr_req = 1'b0;
                else wr_data = 32'(nw);
            end
            if (rd_ack) begin
                chk("order_data", 64'(rd_data), 64'(nr));
                nr++;
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        chk("order_count", 64'(nr), 64'd40);
        tick();

        // Simultaneous read and write at level 5.
        for (int i = 0; i < 5; i++) write_word(32'h100 + 32'(i));
        tick();
        chk("sim_level5_pre", 64'(level), 64'd5);
        wr_data = 32'h200;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        tick();
        wr_req = 1'b0;
        rd_req = 1'b0;
        chk("sim_wr_ack", 64'(wr_ack), 64'd1);
        chk("sim_rd_ack", 64'(rd_ack), 64'd1);
        chk("sim_level5", 64'(level), 64'd5);
        chk("sim_rd_data", 64'(rd_data), 64'h100);

        // Reset mid-stream at level 7, then fresh data only.
        write_word(32'h300);
        write_word(32'h301);
        tick();
        chk("mid_level7", 64'(level), 64'd7);
        mid_cycle_reset();
        write_word(32'hA5A5A5A5);
        read_word(rv);
        chk("post_rst_data", 64'(rv), 64'hA5A5A5A5);
        tick();
        chk("post_rst_empty", 64'(empty), 64'd1);

        // Randomized traffic against the model.
        wr_data = $urandom;
        for (int c = 0; c < 400; c++) begin
            wr_req = ($urandom_range(0, 3) != 0);
            rd_req = ($urandom_range(0, 2) == 0);
            tick();
            if (wr_ack) wr_data = $urandom;
        end
        wr_req = 1'b0;
        rd_req = 1'b1;
        repeat (40) tick();
        rd_req = 1'b0;
        tick();
        chk("rand_drained", 64'(empty), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
